// File: rtl/irq_trap_ctrl_pkg.sv
// Shared types and cause constants for the interrupt/trap-entry controller.
package irq_trap_ctrl_pkg;

  localparam int unsigned CauseCodeW = 5;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    TAKE  = 2'd2,
    SLEEP = 2'd3
  } irq_trap_state_e;

  // Trap cause as presented to the CSR file: interrupt flag plus code
  typedef struct packed {
    logic                  irq;
    logic [CauseCodeW-1:0] code;
  } irq_cause_t;

  localparam irq_cause_t IrqCauseNm       = '{irq: 1'b1, code: 5'd31};
  localparam irq_cause_t IrqCauseExternal = '{irq: 1'b1, code: 5'd11};
  localparam irq_cause_t IrqCauseSoftware = '{irq: 1'b1, code: 5'd3};
  localparam irq_cause_t IrqCauseTimer    = '{irq: 1'b1, code: 5'd7};
  localparam irq_cause_t IrqCauseFastBase = '{irq: 1'b1, code: 5'd16};

endpackage

// File: rtl/irq_trap_ctrl_prio_enc.sv
// Priority encoder: NMI > fast (lowest index) > external > software > timer.
// Ports:
//   pending  in  NUM_FAST+3  enabled requests {fast, external, timer, software}
//   irq_nm   in  1           non-maskable request (already filtered by caller)
//   valid_c  out 1           any request present
//   cause_c  out irq_cause_t winning cause
module irq_prio_enc
  import irq_trap_ctrl_pkg::*;
#(
  parameter int unsigned NUM_FAST = 15
) (
  input  logic [NUM_FAST+2:0] pending,
  input  logic                irq_nm,
  output logic                valid_c,
  output irq_cause_t          cause_c
);

  // Later assignments override earlier ones, so lowest priority goes first.
  always_comb begin
    valid_c = irq_nm | (|pending);
    cause_c = '0;
    if (pending[1]) cause_c = IrqCauseTimer;
    if (pending[0]) cause_c = IrqCauseSoftware;
    if (pending[2]) cause_c = IrqCauseExternal;
    for (int i = int'(NUM_FAST) - 1; i >= 0; i--) begin
      if (pending[3+i]) begin
        cause_c.irq  = 1'b1;
        cause_c.code = IrqCauseFastBase.code + 5'(i);
      end
    end
    if (irq_nm) cause_c = IrqCauseNm;
  end

endmodule

// File: rtl/irq_trap_ctrl.sv
// Interrupt arbitration and trap-entry controller: drains the pipeline via a
// halt handshake, pulses pc_set/csr_save with a registered cause, tracks NMI
// mode, WFI sleep/wake and counts trap entries (saturating).
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   irq_*_i, irq_fast_i, irq_nm_i level interrupt requests
//   mie_i, mstatus_mie_i          per-source and global enables
//   debug_mode_i, single_step_i,
//   debug_req_i                   debug status / wake request
//   halt_ack_i                    pipeline drained
//   mret_i, wfi_i                 retiring MRET / WFI
//   halt_req_o, pc_set_o,
//   csr_save_o, exc_cause_o       pipeline halt and trap-entry outputs
//   nmi_mode_o, core_sleep_o      status
//   irq_taken_cnt_o               saturating trap-entry count
module irq_trap_ctrl
  import irq_trap_ctrl_pkg::*;
#(
  parameter int unsigned NUM_FAST = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                irq_software_i,
  input  logic                irq_timer_i,
  input  logic                irq_external_i,
  input  logic [NUM_FAST-1:0] irq_fast_i,
  input  logic                irq_nm_i,
  input  logic [NUM_FAST+2:0] mie_i,
  input  logic                mstatus_mie_i,
  input  logic                debug_mode_i,
  input  logic                single_step_i,
  input  logic                debug_req_i,
  input  logic                halt_ack_i,
  input  logic                mret_i,
  input  logic                wfi_i,
  output logic                halt_req_o,
  output logic                pc_set_o,
  output logic                csr_save_o,
  output logic [5:0]          exc_cause_o,
  output logic                nmi_mode_o,
  output logic                core_sleep_o,
  output logic [CNT_W-1:0]    irq_taken_cnt_o
);

  irq_trap_state_e  state_q, state_d;
  irq_cause_t       cause_q, cause_d;
  logic             nmi_mode_q, nmi_mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_FAST+2:0] pending;
  logic                nm_eff;
  logic                enc_valid;
  irq_cause_t          enc_cause;
  logic                take;
  logic                wake;

  assign pending = {irq_fast_i, irq_external_i, irq_timer_i, irq_software_i} & mie_i;
  // No nested NMI: the request is invisible while already in the handler.
  assign nm_eff  = irq_nm_i & ~nmi_mode_q;

  irq_prio_enc #(.NUM_FAST(NUM_FAST)) u_prio_enc (
    .pending (pending),
    .irq_nm  (nm_eff),
    .valid_c (enc_valid),
    .cause_c (enc_cause)
  );

  assign take = ~debug_mode_i & ~single_step_i & ~nmi_mode_q &
                (nm_eff | (mstatus_mie_i & (|pending)));
  // Wake ignores the global enable; enc_valid already covers pending and NMI.
  assign wake = enc_valid | debug_req_i;

  // Next-state and bookkeeping
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    nmi_mode_d = nmi_mode_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          state_d = DRAIN;
          cause_d = enc_cause;
        end else if (wfi_i) begin
          state_d = SLEEP;
        end else if (mret_i) begin
          nmi_mode_d = 1'b0;
        end
      end
      DRAIN: begin
        if (!take) begin
          state_d = IDLE;
        end else begin
          if (irq_nm_i && (cause_q != IrqCauseNm)) cause_d = IrqCauseNm;
          if (halt_ack_i) state_d = TAKE;
        end
      end
      TAKE: begin
        if (cause_q == IrqCauseNm) nmi_mode_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      SLEEP: begin
        if (wake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cause_q      <= '0;
      nmi_mode_q   <= 1'b0;
      cnt_q        <= '0;
      halt_req_o   <= 1'b0;
      pc_set_o     <= 1'b0;
      csr_save_o   <= 1'b0;
      core_sleep_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      nmi_mode_q   <= nmi_mode_d;
      cnt_q        <= cnt_d;
      halt_req_o   <= (state_d != IDLE);
      pc_set_o     <= (state_d == TAKE);
      csr_save_o   <= (state_d == TAKE);
      core_sleep_o <= (state_d == SLEEP);
    end
  end

  assign exc_cause_o     = cause_q;
  assign nmi_mode_o      = nmi_mode_q;
  assign irq_taken_cnt_o = cnt_q;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Self-checking bench for irq_trap_ctrl: directed scenarios then random
// stimulus against a behavioural model. A second instance with a 2-bit
// counter exercises saturation.
module tb_irq_trap_ctrl;

  localparam int NF = 15;

  localparam int P_IDLE  = 0;
  localparam int P_DRAIN = 1;
  localparam int P_TAKE  = 2;
  localparam int P_SLEEP = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          irq_sw, irq_tim, irq_ext, irq_nm;
  logic [NF-1:0] irq_fast;
  logic [NF+2:0] mie;
  logic          mstatus_mie, debug_mode, single_step, debug_req;
  logic          halt_ack, mret, wfi;

  logic          halt_req, pc_set, csr_save, nmi_mode, core_sleep;
  logic [5:0]    exc_cause;
  logic [15:0]   cnt16;
  logic          halt_req_s, pc_set_s, csr_save_s, nmi_mode_s, core_sleep_s;
  logic [5:0]    exc_cause_s;
  logic [1:0]    cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state
  int         m_phase;
  logic [5:0] m_cause;
  logic       m_nmi;
  int         m_cnt;

  always #5 clk = ~clk;

  irq_trap_ctrl #(.NUM_FAST(NF), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .irq_software_i(irq_sw), .irq_timer_i(irq_tim), .irq_external_i(irq_ext),
    .irq_fast_i(irq_fast), .irq_nm_i(irq_nm), .mie_i(mie),
    .mstatus_mie_i(mstatus_mie), .debug_mode_i(debug_mode),
    .single_step_i(single_step), .debug_req_i(debug_req),
    .halt_ack_i(halt_ack), .mret_i(mret), .wfi_i(wfi),
    .halt_req_o(halt_req), .pc_set_o(pc_set), .csr_save_o(csr_save),
    .exc_cause_o(exc_cause), .nmi_mode_o(nmi_mode),
    .core_sleep_o(core_sleep), .irq_taken_cnt_o(cnt16)
  );

  irq_trap_ctrl #(.NUM_FAST(NF), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .irq_software_i(irq_sw), .irq_timer_i(irq_tim), .irq_external_i(irq_ext),
    .irq_fast_i(irq_fast), .irq_nm_i(irq_nm), .mie_i(mie),
    .mstatus_mie_i(mstatus_mie), .debug_mode_i(debug_mode),
    .single_step_i(single_step), .debug_req_i(debug_req),
    .halt_ack_i(halt_ack), .mret_i(mret), .wfi_i(wfi),
    .halt_req_o(halt_req_s), .pc_set_o(pc_set_s), .csr_save_o(csr_save_s),
    .exc_cause_o(exc_cause_s), .nmi_mode_o(nmi_mode_s),
    .core_sleep_o(core_sleep_s), .irq_taken_cnt_o(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Highest-priority cause among NMI and the enabled pending sources
  function automatic logic [5:0] winner(input logic nm, input logic [NF+2:0] p);
    if (nm) return 6'h3F;
    for (int i = 0; i < NF; i++) if (p[3+i]) return 6'(6'h30 + i);
    if (p[2]) return 6'h2B;
    if (p[0]) return 6'h23;
    if (p[1]) return 6'h27;
    return 6'h00;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_cause = 6'h00;
    m_nmi   = 1'b0;
    m_cnt   = 0;
  endtask

  // One clock of the reference behaviour, evaluated from current inputs
  task automatic model_step();
    logic [NF+2:0] pend;
    logic          nm_seen, take;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pend    = {irq_fast, irq_ext, irq_tim, irq_sw} & mie;
    nm_seen = irq_nm && !m_nmi;
    take    = !debug_mode && !single_step && !m_nmi && (nm_seen || (mstatus_mie && pend != 0));
    case (m_phase)
      P_IDLE: begin
        if (take) begin
          m_phase = P_DRAIN;
          m_cause = winner(nm_seen, pend);
        end else if (wfi) m_phase = P_SLEEP;
        else if (mret) m_nmi = 1'b0;
      end
      P_DRAIN: begin
        if (!take) m_phase = P_IDLE;
        else begin
          if (irq_nm) m_cause = 6'h3F;
          if (halt_ack) m_phase = P_TAKE;
        end
      end
      P_TAKE: begin
        if (m_cause == 6'h3F) m_nmi = 1'b1;
        m_cnt++;
        m_phase = P_IDLE;
      end
      default: begin
        if (pend != 0 || nm_seen || debug_req) m_phase = P_IDLE;
      end
    endcase
  endtask

  task automatic compare_all();
    int c16, c2;
    c16 = (m_cnt > 65535) ? 65535 : m_cnt;
    c2  = (m_cnt > 3) ? 3 : m_cnt;
    check("halt_req",   32'(halt_req),   32'(m_phase != P_IDLE));
    check("pc_set",     32'(pc_set),     32'(m_phase == P_TAKE));
    check("csr_save",   32'(csr_save),   32'(m_phase == P_TAKE));
    check("core_sleep", 32'(core_sleep), 32'(m_phase == P_SLEEP));
    check("nmi_mode",   32'(nmi_mode),   32'(m_nmi));
    check("cnt16",      32'(cnt16),      32'(c16));
    check("cnt2",       32'(cnt2),       32'(c2));
    if (m_phase == P_TAKE) begin
      check("exc_cause",   32'(exc_cause),   32'(m_cause));
      check("exc_cause_s", 32'(exc_cause_s), 32'(m_cause));
    end
    check("pc_set_s",   32'(pc_set_s),   32'(m_phase == P_TAKE));
    check("halt_req_s", 32'(halt_req_s), 32'(m_phase != P_IDLE));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic quiet();
    irq_sw = 0; irq_tim = 0; irq_ext = 0; irq_nm = 0; irq_fast = '0;
    mie = '0; mstatus_mie = 1; debug_mode = 0; single_step = 0;
    debug_req = 0; halt_ack = 0; mret = 0; wfi = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_halt"},  32'(halt_req),   0);
    check({tag, "_pc"},    32'(pc_set),     0);
    check({tag, "_save"},  32'(csr_save),   0);
    check({tag, "_cause"}, 32'(exc_cause),  0);
    check({tag, "_nmi"},   32'(nmi_mode),   0);
    check({tag, "_sleep"}, 32'(core_sleep), 0);
    check({tag, "_cnt"},   32'(cnt16),      0);
  endtask

  initial begin
    int saved;
    quiet();
    rst_n = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    rst_n = 1;
    #4;

    // Timer with ack tied high: pulse two cycles after the request edge
    mie = 18'h2; irq_tim = 1; halt_ack = 1;
    cyc(); check("t_halt", 32'(halt_req), 1);
    cyc(); check("t_pc", 32'(pc_set), 1); check("t_cause", 32'(exc_cause), 32'h27);
    irq_tim = 0;
    cyc(); check("t_cnt", 32'(cnt16), 1); check("t_pc_off", 32'(pc_set), 0);

    // Fast 2, fast 5 and external together: fast 2 wins
    mie = '1; irq_fast = 15'h0024; irq_ext = 1;
    cyc(); cyc(); check("f_cause", 32'(exc_cause), 32'h32);
    quiet(); cyc();

    // NMI arriving during drain upgrades the cause
    mie = 18'h4; irq_ext = 1;
    cyc(); check("n_drain", 32'(halt_req), 1);
    irq_nm = 1; cyc();
    halt_ack = 1; cyc(); check("n_cause", 32'(exc_cause), 32'h3F);
    irq_nm = 0; irq_ext = 0; halt_ack = 0;
    cyc(); check("n_mode", 32'(nmi_mode), 1);
    irq_nm = 1; halt_ack = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); check("n_nested", 32'(halt_req), 0);
    end
    irq_nm = 0; mret = 1;
    cyc(); check("n_mret", 32'(nmi_mode), 0);
    quiet();

    // Software withdrawn before ack: abort without pulse
    saved = m_cnt;
    mie = 18'h1; irq_sw = 1;
    cyc(); check("a_halt", 32'(halt_req), 1);
    irq_sw = 0;
    cyc(); check("a_halt_off", 32'(halt_req), 0); check("a_pc", 32'(pc_set), 0);
    check("a_cnt", 32'(cnt16), 32'(saved));
    cyc();

    // WFI with interrupts globally off, wake on pending timer, no trap
    mstatus_mie = 0; wfi = 1;
    cyc(); check("w_sleep", 32'(core_sleep), 1);
    wfi = 0; cyc(); check("w_still", 32'(core_sleep), 1);
    mie = 18'h2; irq_tim = 1;
    cyc(); check("w_wake", 32'(core_sleep), 0);
    cyc(); cyc(); check("w_notrap", 32'(halt_req), 0);
    quiet();

    // Five traps: the 2-bit counter saturates
    for (int k = 0; k < 5; k++) begin
      mie = 18'h2; irq_tim = 1; halt_ack = 1;
      cyc(); cyc();
      irq_tim = 0; cyc();
    end
    check("sat_cnt2", 32'(cnt2), 3);

    // Reset pulse in the middle of a drain
    halt_ack = 0; irq_tim = 1;
    cyc(); check("r_drain", 32'(halt_req), 1);
    #2 rst_n = 0;
    #1 check_all_zero("rmid");
    model_reset();
    cyc();
    quiet(); rst_n = 1;
    cyc();

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      irq_fast    = NF'($urandom & $urandom & $urandom & $urandom);
      irq_sw      = ($urandom_range(99) < 15);
      irq_tim     = ($urandom_range(99) < 15);
      irq_ext     = ($urandom_range(99) < 15);
      irq_nm      = ($urandom_range(99) < 8);
      mie         = 18'($urandom & $urandom);
      mstatus_mie = ($urandom_range(99) < 80);
      debug_mode  = ($urandom_range(99) < 5);
      single_step = ($urandom_range(99) < 3);
      debug_req   = ($urandom_range(99) < 5);
      halt_ack    = ($urandom_range(99) < 50);
      mret        = ($urandom_range(99) < 10);
      wfi         = ($urandom_range(99) < 8);
      rst_n       = ($urandom_range(999) >= 5);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_trap_ctrl.md
# irq_trap_ctrl

Parametrised interrupt arbitration and trap-entry controller for the 5-stage core, splitting interrupt handling out of the main pipeline controller. It prioritises NMI, NUM_FAST fast interrupts and the three standard M-mode interrupts, drains the pipeline through a halt handshake, and issues a single-cycle trap-entry pulse with a registered cause. It also owns NMI-mode tracking, WFI sleep/wake and a saturating taken-interrupt counter. It sits between the CSR file (enables) and the IF/pipeline-control logic (halt, PC set).

## Interface
- NUM_FAST, 15, number of fast interrupt lines, legal 1..15
- CNT_W, 16, width of the taken-interrupt counter
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- irq_software_i / irq_timer_i / irq_external_i  in  1 each  level interrupt requests
- irq_fast_i  in  NUM_FAST  level fast interrupt requests
- irq_nm_i  in  1  non-maskable interrupt, level
- mie_i  in  NUM_FAST+3  enables: bit0 software, bit1 timer, bit2 external, bit3+i fast i
- mstatus_mie_i  in  1  global interrupt enable
- debug_mode_i, single_step_i, debug_req_i  in  1 each  debug status/request
- halt_ack_i  in  1  pipeline drained, no instruction in flight
- mret_i  in  1  valid MRET retiring
- wfi_i  in  1  valid WFI retiring
- halt_req_o  out  1  request pipeline halt/drain
- pc_set_o  out  1  one-cycle trap-entry pulse; IF loads trap vector
- csr_save_o  out  1  same timing as pc_set_o; CSR saves mepc/mcause
- exc_cause_o  out  6  [5] interrupt flag, [4:0] code
- nmi_mode_o  out  1  in NMI handler
- core_sleep_o  out  1  core asleep
- irq_taken_cnt_o  out  CNT_W  saturating count of trap entries

## Operation
- pending = {irq_fast_i, irq_external_i, irq_timer_i, irq_software_i} & mie_i.
- Priority: NMI > fast (lowest index first) > external > software > timer.
- Cause codes: NMI {1,31}; fast i {1,16+i}; external {1,11}; software {1,3}; timer {1,7}.
- take = ~debug_mode_i & ~single_step_i & ~nmi_mode_q & (irq_nm_i | (mstatus_mie_i & |pending)).
- States: IDLE, DRAIN, TAKE, SLEEP.
- IDLE: take -> DRAIN, latch winning cause in cause_q. Else wfi_i -> SLEEP. Else mret_i clears nmi_mode_q. take with wfi_i: take wins.
- DRAIN: halt_req_o=1.
  - irq_nm_i rising into take while the latched cause is not NMI: cause_q upgraded to NMI.
  - take deasserts (source withdrawn, debug entered, mstatus_mie_i cleared) before halt_ack_i: abort to IDLE, no pulse, counter unchanged.
  - halt_ack_i with take still true: -> TAKE.
- TAKE: pc_set_o=csr_save_o=1, halt_req_o=1. If cause_q is NMI, set nmi_mode_q. Counter +1, saturating at all-ones. -> IDLE.
- SLEEP: core_sleep_o=1, halt_req_o=1. Wake to IDLE on |pending (mstatus_mie_i ignored), irq_nm_i or debug_req_i.
- mret_i is ignored outside IDLE.
- No nested NMI: irq_nm_i is ignored while nmi_mode_q=1.

## Timing
- Reset: state IDLE; all outputs 0; cause_q 0; nmi_mode_q 0; counter 0.
- All outputs decode from registered state/cause_q only; no combinational input-to-output paths.
- Request sampled at edge n -> halt_req_o from n+1. halt_ack_i high at n+1 -> pc_set_o at n+2 -> IDLE at n+3. Minimum entry latency is 2 cycles.
- exc_cause_o holds cause_q continuously; it is meaningful only while pc_set_o=1.
- Wake from SLEEP: condition at edge n -> core_sleep_o low at n+1. A trap, if take holds, follows through DRAIN.
- rst_n asserted in any state returns to IDLE immediately; no pulse is issued.

## Structure
- Shared pkg: irq_trap_state_e, irq_cause_t (packed {irq, code[4:0]}), cause constants IrqCauseNm/External/Software/Timer/FastBase.
- Sub-module irq_prio_enc: parametrised NUM_FAST priority encoder producing valid and irq_cause_t from pending and irq_nm_i.

## Test plan
- Timer irq, mie_i[1]=1, mstatus_mie_i=1, halt_ack_i tied high -> pc_set_o 2 cycles later, exc_cause_o=6'h27, counter=1.
- Fast 2 and fast 5 plus external together -> cause 6'h32 (fast 2).
- External pending, irq_nm_i asserted during DRAIN, then ack -> cause 6'h3F, nmi_mode_o=1. Second NMI ignored until mret_i, after which nmi_mode_o=0.
- Software irq withdrawn during DRAIN before ack -> halt_req_o drops, no pc_set_o, counter unchanged.
- wfi_i with mstatus_mie_i=0, then timer pending with mie_i[1]=1 -> core_sleep_o 1 then 0 the cycle after. No trap is taken.
- CNT_W=2, five traps -> irq_taken_cnt_o saturates at 3. rst_n pulse mid-DRAIN -> all outputs 0.
